// File: rtl/maze_ctrl.sv
// Maze game controller: 8x8 LED matrix row scan plus player movement with
// wall lookup through a shared map ROM port, collision hold and win state.
module maze_ctrl #(
  parameter int unsigned START_X  = 1,
  parameter int unsigned START_Y  = 1,
  parameter int unsigned HIT_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_tick,
  input  logic       move_tick,
  input  logic [3:0] btn,
  input  logic [7:0] map_data,
  output logic [3:0] map_addr,
  output logic [7:0] row_sel,
  output logic [7:0] col_green,
  output logic [7:0] col_red,
  output logic       coll,
  output logic       win
);

  typedef enum logic [1:0] {PLAY, LOOK, HIT, WIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  px_q, px_d, py_q, py_d;
  logic [2:0]  tx_q, tx_d, ty_q, ty_d;
  logic [2:0]  scan_idx_q, scan_idx_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;
  logic        scan_pend_q, scan_pend_d;
  logic [7:0]  row_sel_q, row_sel_d;
  logic [7:0]  col_green_q, col_green_d;
  logic [7:0]  col_red_q, col_red_d;
  logic        coll_q, coll_d;
  logic        win_q, win_d;

  logic        mv_ok;
  logic [2:0]  nx, ny;

  // The game lookup owns the ROM port for the single LOOK cycle.
  assign map_addr  = (state_q == LOOK) ? {1'b0, ty_q} : {coll_q, scan_idx_q};
  assign row_sel   = row_sel_q;
  assign col_green = col_green_q;
  assign col_red   = col_red_q;
  assign coll      = coll_q;
  assign win       = win_q;

  always_comb begin
    mv_ok = 1'b0;
    nx    = px_q;
    ny    = py_q;
    if (btn[3]) begin
      mv_ok = (py_q != 3'd0);
      ny    = py_q - 3'd1;
    end else if (btn[2]) begin
      mv_ok = (py_q != 3'd7);
      ny    = py_q + 3'd1;
    end else if (btn[1]) begin
      mv_ok = (px_q != 3'd0);
      nx    = px_q - 3'd1;
    end else if (btn[0]) begin
      mv_ok = (px_q != 3'd7);
      nx    = px_q + 3'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    px_d        = px_q;
    py_d        = py_q;
    tx_d        = tx_q;
    ty_d        = ty_q;
    scan_idx_d  = scan_idx_q;
    hold_cnt_d  = hold_cnt_q;
    scan_pend_d = scan_pend_q;
    row_sel_d   = row_sel_q;
    col_green_d = col_green_q;
    col_red_d   = col_red_q;
    coll_d      = coll_q;
    win_d       = win_q;

    if (state_q == LOOK) begin
      if (scan_tick) scan_pend_d = 1'b1;
    end else if (scan_tick || scan_pend_q) begin
      col_green_d = map_data;
      row_sel_d   = 8'd1 << scan_idx_q;
      col_red_d   = (scan_idx_q == py_q) ? (8'd1 << px_q) : 8'd0;
      scan_idx_d  = scan_idx_q + 3'd1;
      // A fresh tick landing on a pending service stays queued, not lost.
      scan_pend_d = scan_pend_q && scan_tick;
    end

    case (state_q)
      PLAY: begin
        if (move_tick && mv_ok) begin
          tx_d    = nx;
          ty_d    = ny;
          state_d = LOOK;
        end
      end
      LOOK: begin
        if (map_data[tx_q]) begin
          state_d    = HIT;
          coll_d     = 1'b1;
          hold_cnt_d = 8'(HIT_HOLD);
        end else begin
          px_d = tx_q;
          py_d = ty_q;
          if (ty_q == 3'd7) begin
            state_d = WIN;
            win_d   = 1'b1;
          end else begin
            state_d = PLAY;
          end
        end
      end
      HIT: begin
        if (move_tick) begin
          hold_cnt_d = hold_cnt_q - 8'd1;
          if (hold_cnt_q == 8'd1) begin
            coll_d  = 1'b0;
            state_d = PLAY;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      px_q        <= 3'(START_X);
      py_q        <= 3'(START_Y);
      tx_q        <= 3'd0;
      ty_q        <= 3'd0;
      scan_idx_q  <= 3'd0;
      hold_cnt_q  <= 8'd0;
      scan_pend_q <= 1'b0;
      row_sel_q   <= 8'd0;
      col_green_q <= 8'd0;
      col_red_q   <= 8'd0;
      coll_q      <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      px_q        <= px_d;
      py_q        <= py_d;
      tx_q        <= tx_d;
      ty_q        <= ty_d;
      scan_idx_q  <= scan_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      scan_pend_q <= scan_pend_d;
      row_sel_q   <= row_sel_d;
      col_green_q <= col_green_d;
      col_red_q   <= col_red_d;
      coll_q      <= coll_d;
      win_q       <= win_d;
    end
  end

endmodule

// File: tb/tb_maze_ctrl.sv
// Directed bench for maze_ctrl: scan walk, collision hold, moves, win,
// scan deferral across LOOK, coincident ticks and reset during HIT.
module tb_maze_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scan_tick = 1'b0;
  logic       move_tick = 1'b0;
  logic [3:0] btn = 4'd0;
  logic [7:0] map_data;
  logic [3:0] map_addr;
  logic [7:0] row_sel, col_green, col_red;
  logic       coll, win;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] sidx = 3'd0;

  localparam logic [3:0] B_UP = 4'b1000, B_DN = 4'b0100, B_LT = 4'b0010, B_RT = 4'b0001;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_row(input logic [2:0] r);
    case (r)
      3'd0: rom_row = 8'hFF;
      3'd3: rom_row = 8'h99;
      3'd7: rom_row = 8'hF1;
      default: rom_row = 8'h81;
    endcase
  endfunction

  assign map_data = map_addr[3] ? 8'hFF : rom_row(map_addr[2:0]);

  maze_ctrl #(.START_X(1), .START_Y(1), .HIT_HOLD(8)) dut (
    .clk(clk), .rst_n(rst_n), .scan_tick(scan_tick), .move_tick(move_tick),
    .btn(btn), .map_data(map_data), .map_addr(map_addr), .row_sel(row_sel),
    .col_green(col_green), .col_red(col_red), .coll(coll), .win(win)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    sidx  = 3'd0;
  endtask

  task automatic pulse_scan();
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
  endtask

  // Leaves the FSM in LOOK when the move is accepted.
  task automatic pulse_move(input logic [3:0] b);
    btn = b;
    move_tick = 1'b1;
    step();
    move_tick = 1'b0;
    btn = 4'd0;
  endtask

  task automatic do_move(input logic [3:0] b);
    pulse_move(b);
    step();
  endtask

  task automatic frame(input string tag, input logic [2:0] epx, input logic [2:0] epy,
                       input bit full);
    logic [7:0] one;
    one = 8'd1;
    for (int i = 0; i < 8; i++) begin
      pulse_scan();
      chk({tag, " row_sel"}, row_sel, one << sidx);
      chk({tag, " green"}, col_green, full ? 8'hFF : rom_row(sidx));
      chk({tag, " red"}, col_red, (sidx == epy) ? (one << epx) : 8'd0);
      sidx = sidx + 3'd1;
    end
  endtask

  initial begin
    do_reset();
    chk("rst row_sel", row_sel, 8'h00);
    chk("rst green", col_green, 8'h00);
    chk("rst red", col_red, 8'h00);
    chk("rst coll", coll, 1'b0);
    chk("rst win", win, 1'b0);
    chk("rst map_addr", map_addr, 4'h0);

    frame("walk", 3'd1, 3'd1, 1'b0);

    // Wall above the start: LOOK at row 0, then collision hold.
    pulse_scan();
    sidx = sidx + 3'd1;
    chk("idle addr", map_addr, 4'h1);
    pulse_move(B_UP);
    chk("look addr", map_addr, 4'h0);
    step();
    chk("hit coll", coll, 1'b1);
    chk("hit addr", map_addr, {1'b1, sidx});
    frame("hit", 3'd1, 3'd1, 1'b1);
    for (int i = 0; i < 7; i++) pulse_move(B_UP);
    chk("hold 7", coll, 1'b1);
    pulse_move(B_DN);
    chk("hold 8", coll, 1'b0);
    chk("after hit addr", map_addr, {1'b0, sidx});
    frame("after hit", 3'd1, 3'd1, 1'b0);

    do_reset();
    do_move(B_DN);
    do_move(B_RT);
    do_move(B_DN);
    frame("path", 3'd2, 3'd3, 1'b0);
    pulse_move(B_RT);
    chk("wall look addr", map_addr, 4'h3);
    step();
    chk("wall coll", coll, 1'b1);
    rst_n = 1'b0;
    step();
    chk("hit rst coll", coll, 1'b0);
    chk("hit rst addr", map_addr, 4'h0);
    chk("hit rst row_sel", row_sel, 8'h00);
    rst_n = 1'b1;
    sidx = 3'd0;
    do_move(B_DN);
    frame("post rst", 3'd1, 3'd2, 1'b0);

    do_reset();
    for (int i = 0; i < 5; i++) do_move(B_DN);
    chk("pre win", win, 1'b0);
    do_move(B_DN);
    chk("win", win, 1'b1);
    do_move(B_UP);
    do_move(B_RT);
    chk("win addr", map_addr, {1'b0, sidx});
    chk("win held", win, 1'b1);
    frame("win", 3'd1, 3'd7, 1'b0);

    // Scan tick during LOOK is deferred by one cycle, serviced once.
    do_reset();
    pulse_scan();
    sidx = 3'd1;
    pulse_move(B_RT);
    scan_tick = 1'b1;
    step();
    scan_tick = 1'b0;
    chk("defer row_sel", row_sel, 8'h01);
    step();
    chk("defer svc row_sel", row_sel, 8'h02);
    chk("defer svc red", col_red, 8'h04);
    step();
    chk("defer once", row_sel, 8'h02);
    pulse_scan();
    chk("defer next", row_sel, 8'h04);

    // Coincident ticks, priority and idle move.
    do_reset();
    scan_tick = 1'b1;
    move_tick = 1'b1;
    btn = B_DN | B_RT;
    step();
    scan_tick = 1'b0;
    move_tick = 1'b0;
    btn = 4'd0;
    chk("coinc row_sel", row_sel, 8'h01);
    chk("coinc look addr", map_addr, 4'h2);
    step();
    chk("coinc play addr", map_addr, 4'h1);
    pulse_move(4'd0);
    chk("no btn addr", map_addr, 4'h1);
    sidx = 3'd1;
    frame("coinc", 3'd1, 3'd2, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/maze_ctrl.md
MAZE_CTRL -- requirements
Module: maze_ctrl

Interface
REQ-001 SHALL have parameter START_X, default 1, meaning player start column (0-7).
REQ-002 SHALL have parameter START_Y, default 1, meaning player start row (0-7).
REQ-003 SHALL have parameter HIT_HOLD, default 8, meaning the number of move_tick periods the collision display is held (1-255).
REQ-004 SHALL have port clk  in  1  the single system clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port scan_tick  in  1  one-cycle pulse that advances the display row scan.
REQ-007 SHALL have port move_tick  in  1  one-cycle pulse that samples the buttons and counts down the hit hold.
REQ-008 SHALL have port btn  in  4  {up, down, left, right}, active-high, level.
REQ-009 SHALL have port map_data  in  8  row data from the map ROM (1 = wall); bit c = column c; combinational from map_addr.
REQ-010 SHALL have port map_addr  out  4  {coll, row index} to the map ROM.
REQ-011 SHALL have port row_sel  out  8  one-hot active-high row drive.
REQ-012 SHALL have port col_green  out  8  wall pixels for the driven row.
REQ-013 SHALL have port col_red  out  8  player pixel for the driven row.
REQ-014 SHALL have port coll  out  1  collision display active.
REQ-015 SHALL have port win  out  1  player reached row 7.

Function
REQ-016 SHALL implement FSM states PLAY, LOOK, HIT and WIN.
REQ-017 SHALL keep registers px, py (3 b each), scan_idx (3 b), tx, ty (3 b each), hold_cnt (8 b) and scan_pend (1 b).
REQ-018 SHALL drive map_addr = {coll, scan_idx} in PLAY, HIT and WIN, and {0, ty} in LOOK (ROM arbitration: game lookup wins).
REQ-019 SHALL, on a serviced scan (scan_tick, or scan_pend, outside LOOK), in one cycle: col_green <= map_data; row_sel <= onehot(scan_idx); col_red <= (scan_idx==py) ? onehot(px) : 0; scan_idx <= scan_idx+1 mod 8; scan_pend <= 0.
REQ-020 SHALL, on scan_tick in LOOK, set scan_pend, with the scan serviced the cycle after LOOK exits; it SHALL NOT drop or double-count any scan.
REQ-021 SHALL, in PLAY on move_tick, take the direction with priority up>down>left>right; up = py-1, down = py+1, left = px-1, right = px+1.
REQ-022 SHALL ignore a move request when no button is pressed or the target lies outside 0-7 (no wrap), staying in PLAY.
REQ-023 SHALL, on an accepted move request, register tx, ty and go to LOOK the next cycle.
REQ-024 SHALL make LOOK last exactly one cycle; if map_data[tx]==1, next state is HIT, coll<=1, hold_cnt<=HIT_HOLD, and px, py are unchanged.
REQ-025 SHALL, in LOOK with map_data[tx]==0, set px<=tx and py<=ty, then go to WIN (win<=1) if ty==7, else PLAY.
REQ-026 SHALL, in HIT, ignore buttons, keep scanning with coll=1 (ROM returns full rows), and decrement hold_cnt on each move_tick.
REQ-027 SHALL, in HIT when a move_tick arrives with hold_cnt==1, clear coll and return to PLAY.
REQ-028 SHALL make WIN terminal until reset: buttons ignored, scanning continues, win=1.
REQ-029 SHALL, when scan_tick and move_tick coincide in PLAY, service the scan with the scan address that cycle and enter LOOK on the next cycle.
REQ-030 SHALL introduce a move-to-display latency of at most 2 cycles after the next serviced scan of row py.

Reset
REQ-031 SHALL, while rst_n=0 at a clk edge, set state=PLAY, px=START_X, py=START_Y, scan_idx=0, tx=ty=0, hold_cnt=0, scan_pend=0, and map_addr=0, row_sel=0, col_green=0, col_red=0, coll=0, win=0.
REQ-032 SHALL, on reset asserted in any state (including LOOK or HIT), take the reset values at the next edge, with no pending move or scan retained.

Verification
REQ-033 SHALL be verified by: reset, then 8 scan_ticks -> row_sel walks 0x01..0x80; col_green = FF, 81, 81, 99, 81, 81, 81, F1; col_red=0x02 only when row_sel=0x02.
REQ-034 SHALL be verified by: btn=up with move_tick from (1,1) -> LOOK with map_addr=0x0; then HIT; coll=1; col_green=FF on all rows; after 8 move_ticks coll=0 and position is (1,1).
REQ-035 SHALL be verified by: down, right, down from (1,1) -> (2,3) accepted (row 3 bit2=0); then right -> target (3,3) is a wall -> HIT.
REQ-036 SHALL be verified by: down x6 from (1,1) -> py=7 -> win=1; further buttons leave px=1, py=7.
REQ-037 SHALL be verified by: scan_tick in the LOOK cycle -> exactly one scan serviced on the cycle after LOOK; scan_idx advanced by 1.
REQ-038 SHALL be verified by: rst_n=0 during HIT -> coll=0, state PLAY, position (1,1) at the next edge.
